ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit that consumes `pc_current` from `pc_reg` and drives `pc_next` back into it, closing the PC loop. It issues word fetch requests to instruction memory over a valid/ready request channel and collects in-order responses. Results are buffered in a small queue and presented to decode as `{pc, instr}` pairs over a valid/ready handshake. Branch/jump redirects from execute flush the queue and discard in-flight responses.

## Interface
- `ADDR_WIDTH`, default 32: PC/address width (from `my_pkg`).
- `DATA_WIDTH`, default 32: instruction width.
- `DEPTH`, default 2: instruction queue depth, which also bounds outstanding requests. Must be a power of 2, ≥2.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc_current` in ADDR_WIDTH: current PC from `pc_reg`.
- `pc_next` out ADDR_WIDTH: next PC to `pc_reg` (combinational).
- `redirect_valid` in 1: flush and redirect request from execute.
- `redirect_pc` in ADDR_WIDTH: redirect target; bits [1:0] forced to 0.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out ADDR_WIDTH: fetch address (= `pc_current`).
- `imem_rsp_valid` in 1: response valid. Responses are in order and always accepted.
- `imem_rsp_data` in DATA_WIDTH: fetched instruction.
- `id_valid` out 1: decode entry valid.
- `id_ready` in 1: decode accepts entry.
- `id_pc` out ADDR_WIDTH: PC of the presented instruction.
- `id_instr` out DATA_WIDTH: presented instruction.

## Operation
- **State:**
  - `run` bit: 0 at reset, 1 from the first edge after reset release.
  - `outstanding` counter, 0..DEPTH.
  - `kill` counter, 0..DEPTH.
  - Tag queue holding PCs of in-flight requests, DEPTH entries.
  - Instruction queue holding `{pc, instr}`, DEPTH entries.
- **Credit:** `credit = (outstanding + iq_count) < DEPTH`, with `outstanding` including killed requests. This guarantees every accepted response has a queue slot.
- **Request:** `imem_req_valid = run & credit & !redirect_valid`.
  - On accept (valid & ready), push `pc_current` into the tag queue and increment `outstanding`.
- **Next PC** (mux priority):
  1. `redirect_valid`: `{redirect_pc[ADDR_WIDTH-1:2], 2'b00}`.
  2. Request accepted: `pc_current + 4`, wrapping modulo 2^ADDR_WIDTH.
  3. Otherwise: `pc_current`.
- **Response:** on `imem_rsp_valid`, pop the tag queue and decrement `outstanding`.
  - If `kill > 0` (or a redirect is in the same cycle), drop the response and decrement `kill` if nonzero.
  - Otherwise push `{tag, imem_rsp_data}` into the instruction queue.
- **Decode:** `id_valid = iq_count != 0`. The queue pops on `id_valid & id_ready`.
- **Redirect** (single cycle):
  - Instruction queue cleared.
  - No request issued.
  - `kill` loaded with `outstanding` minus 1 if `imem_rsp_valid` that cycle.
  - The tag queue is not cleared; killed responses still pop it.
- **Simultaneous events:**
  - Redirect with decode pop: the queue is cleared regardless.
  - Request accept with response in the same cycle: `outstanding` is unchanged.
  - Push with pop in the same cycle: `iq_count` is unchanged.
- **Errors:** a response with `outstanding == 0` is a protocol error, flagged by a bench assertion. The RTL ignores it.

## Timing
- **Reset values:**
  - `id_valid` = 0, `imem_req_valid` = 0 (`run` = 0).
  - All counters = 0; queue pointers = 0.
  - `pc_next` follows `pc_current`, which is 0x0000_1000 in reset.
- `imem_req_valid` first rises in the 2nd cycle after `rst_n` deasserts.
- With `imem_req_ready` held high, one request per cycle, addresses stepping by 4.
- **Response-to-decode latency:** a response at edge N is visible on `id_*` after edge N, i.e. 1 cycle, registered.
- **Redirect timing:** with redirect asserted in cycle R, the first request to the target is in cycle R+1, because `pc_reg` loads it at edge R.
- **Reset mid-operation:**
  - All state clears asynchronously.
  - Responses arriving after reset for pre-reset requests are the memory's responsibility; the memory is reset together with this block.

## Structure
- `my_pkg` holds `ADDR_WIDTH`, `DATA_WIDTH`, `RESET_PC = 'h0000_1000`, and the `fetch_entry_t` struct `{pc, instr}`.
- One sub-module, `fetch_fifo`: a parameterized synchronous FIFO with push, pop, flush, count, full and empty. It is instantiated twice: as the tag queue and as the instruction queue.
- Counters, credit logic and the PC mux live in `ifu_fetch`.

## Test plan
1. **Reset:** hold `rst_n` low for 3 cycles, `pc_current` = 0x1000.
   - `imem_req_valid` = 0 and `id_valid` = 0 during reset and the 1st cycle after.
   - A request with addr 0x1000 in the 2nd cycle.
2. **Streaming:** `imem_req_ready` = 1, memory latency 1, `id_ready` = 1.
   - Requests at 0x1000, 0x1004, 0x1008, …
   - Decode sees the matching `{pc, instr}` in order, one per cycle, after the pipeline fills.
3. **Backpressure:** `id_ready` = 0.
   - After 2 responses the queue is full and `imem_req_valid` = 0; `pc_next` holds.
   - Releasing `id_ready` resumes issue with no instruction lost or duplicated.
4. **Redirect with in-flight requests:** 2 outstanding requests, redirect to 0x2002.
   - `pc_next` = 0x2000 and the queue is flushed.
   - Both late responses are dropped.
   - The first delivered instruction has `id_pc` = 0x2000.
5. **Redirect coincident with a response and a decode pop:**
   - The response is dropped and `kill` equals the remaining outstanding count.
   - No stale entry reaches decode.
6. **Memory stall and wrap:** `imem_req_ready` = 0 for 5 cycles.
   - `imem_req_addr` is stable and `pc_next` = `pc_current`.
   - Starting with `pc_current` = 0xFFFF_FFFC, an accepted request gives `pc_next` = 0x0000_0000.

Source files
------------

// File: rtl/my_pkg.sv
// Shared fetch-path widths, reset PC and the decode-facing {pc, instr} payload.
package my_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'('h0000_1000);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Word-align an address by clearing the byte offset.
    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head entry is presented combinationally from storage.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full queue is only allowed when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: closes the PC loop, issues credit-limited word fetches,
// tags in-order responses with their PC and queues them for decode; redirects flush.
module ifu_fetch
    import my_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc_current,
    output logic [ADDR_WIDTH-1:0] pc_next,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_instr
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic          run_q;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] kill_q, kill_d;

    logic [CW-1:0]         iq_count, tq_count;
    logic                  iq_full, iq_empty, tq_full, tq_empty;
    logic [ADDR_WIDTH-1:0] tag_head;
    fetch_entry_t          iq_wdata, iq_rdata;

    logic credit, req_fire, rsp_fire, drop, iq_push, id_fire;
    logic unused_fifo_c;

    // Killed requests still hold credit until their response returns.
    assign credit   = ({1'b0, outst_q} + {1'b0, iq_count}) < SW'(DEPTH);
    assign imem_req_valid = run_q & credit & ~redirect_valid;
    assign imem_req_addr  = pc_current;
    assign req_fire = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = imem_rsp_valid & (outst_q != '0);
    assign drop     = (kill_q != '0) | redirect_valid;
    assign iq_push  = rsp_fire & ~drop;

    assign id_valid = (iq_count != '0);
    assign id_fire  = id_valid & id_ready;
    assign id_pc    = iq_rdata.pc;
    assign id_instr = iq_rdata.instr;

    assign iq_wdata.pc    = tag_head;
    assign iq_wdata.instr = imem_rsp_data;

    always_comb begin
        pc_next = pc_current;
        if (redirect_valid)  pc_next = word_align(redirect_pc);
        else if (req_fire)   pc_next = pc_current + ADDR_WIDTH'(4);
    end

    always_comb begin
        outst_d = outst_q;
        kill_d  = kill_q;
        if (req_fire && !rsp_fire)      outst_d = outst_q + CW'(1);
        else if (!req_fire && rsp_fire) outst_d = outst_q - CW'(1);
        // Everything still in flight after this cycle's response belongs to the old path.
        if (redirect_valid)                 kill_d = outst_q - CW'(rsp_fire);
        else if (rsp_fire && kill_q != '0)  kill_d = kill_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            outst_q <= '0;
            kill_q  <= '0;
        end else begin
            run_q   <= 1'b1;
            outst_q <= outst_d;
            kill_q  <= kill_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .wdata_i (pc_current),
        .pop_i   (rsp_fire),
        .rdata_o (tag_head),
        .count_o (tq_count),
        .full_o  (tq_full),
        .empty_o (tq_empty)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (iq_push),
        .wdata_i (iq_wdata),
        .pop_i   (id_fire),
        .rdata_o (iq_rdata),
        .count_o (iq_count),
        .full_o  (iq_full),
        .empty_o (iq_empty)
    );

    assign unused_fifo_c = ^{tq_count, tq_full, tq_empty, iq_full, iq_empty};

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: bench-side pc_reg and memory, queue-based reference model.
module tb_ifu_fetch;
    import my_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [ADDR_WIDTH-1:0] pc_current, pc_next, redirect_pc, imem_req_addr, id_pc;
    logic                  redirect_valid, imem_req_valid, imem_req_ready;
    logic                  imem_rsp_valid, id_valid, id_ready;
    logic [DATA_WIDTH-1:0] imem_rsp_data, id_instr;

    always #5 clk = ~clk;

    // pc_reg lives in the bench and closes the loop through pc_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_current <= RESET_PC;
        else        pc_current <= pc_next;
    end

    ifu_fetch #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_current     (pc_current),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    typedef struct {
        logic [31:0] pc;
        bit          killed;
    } infl_t;

    infl_t        m_infl[$];
    fetch_entry_t m_iq[$];
    bit           m_run;
    logic [31:0]  mem_q[$];
    logic [31:0]  dlv[$];
    int           n_chk = 0;
    int           n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance the model past the edge.
    task automatic cycle(input bit rst, input bit rdy, input bit rsp_en, input bit idr,
                         input bit redir, input logic [31:0] rpc);
        bit          exp_req, fire, rsp, keep;
        logic [31:0] exp_next;
        infl_t       h;
        fetch_entry_t e;
        @(negedge clk);
        rst_n = !rst;
        if (rst) begin
            m_infl.delete(); m_iq.delete(); mem_q.delete(); m_run = 0;
        end
        rsp = !rst && rsp_en && (mem_q.size() > 0);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_q[0]) : $urandom;
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = redir && !rst;
        redirect_pc    = rpc;
        #1;
        exp_req  = m_run && (m_infl.size() + m_iq.size() < DEPTH) && !redirect_valid;
        fire     = exp_req && rdy;
        exp_next = redirect_valid ? {rpc[31:2], 2'b00} : (fire ? pc_current + 32'd4 : pc_current);
        chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
        chk("pc_next", 64'(pc_next), 64'(exp_next));
        chk("id_valid", 64'(id_valid), 64'(m_iq.size() != 0));
        if (exp_req) chk("req_addr", 64'(imem_req_addr), 64'(pc_current));
        if (m_iq.size() != 0) begin
            chk("id_pc", 64'(id_pc), 64'(m_iq[0].pc));
            chk("id_instr", 64'(id_instr), 64'(m_iq[0].instr));
        end
        if (id_valid && idr) dlv.push_back(id_pc);
        if (!rst) begin
            keep = 0;
            if (rsp) begin
                assert (m_infl.size() > 0) else $error("FAIL proto: response with nothing outstanding");
                void'(mem_q.pop_front());
                if (m_infl.size() > 0) begin
                    h = m_infl.pop_front();
                    keep = !h.killed && !redirect_valid;
                end
            end
            if (redirect_valid) begin
                m_iq.delete();
                foreach (m_infl[i]) m_infl[i].killed = 1;
            end else begin
                if (m_iq.size() > 0 && idr) void'(m_iq.pop_front());
                if (keep) begin
                    e.pc = h.pc; e.instr = mem_word(h.pc);
                    m_iq.push_back(e);
                end
            end
            if (fire) m_infl.push_back('{pc: pc_current, killed: 0});
            if (imem_req_valid && rdy) mem_q.push_back(imem_req_addr);
            m_run = 1;
        end
    endtask

    initial begin
        logic [31:0] a0, held;
        bit found;
        rst_n = 1'b1; redirect_valid = 0; redirect_pc = '0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = '0; id_ready = 0;
        #2 rst_n = 1'b0;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 1, 0, 0);
            chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
            chk("rst_id_valid", 64'(id_valid), 64'd0);
            chk("rst_pc_next", 64'(pc_next), 64'h1000);
        end
        dlv.delete();
        cycle(0, 1, 1, 1, 0, 0);
        chk("rel1_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rel1_id_valid", 64'(id_valid), 64'd0);
        cycle(0, 1, 1, 1, 0, 0);
        chk("rel2_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rel2_req_addr", 64'(imem_req_addr), 64'h1000);

        // Streaming.
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 1, 0, 0);
        chk("stream_cnt", 64'(dlv.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < dlv.size(); i++)
            chk("stream_pc", 64'(dlv[i]), 64'(32'h1000 + 32'(4 * i)));

        // Backpressure from decode.
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0, 0);
        chk("bp_id_valid", 64'(id_valid), 64'd1);
        chk("bp_req_valid", 64'(imem_req_valid), 64'd0);
        chk("bp_pc_hold", 64'(pc_next), 64'(pc_current));
        held = id_pc;
        dlv.delete();
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 1, 0, 0);
        chk("bp_resume_cnt", 64'(dlv.size() >= 3), 64'd1);
        if (dlv.size() > 0) chk("bp_resume_head", 64'(dlv[0]), 64'(held));
        for (int i = 1; i < dlv.size(); i++)
            chk("bp_seq", 64'(dlv[i]), 64'(dlv[i-1] + 32'd4));

        // Redirect with two requests in flight.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 0, 0);
        chk("rd_credit_out", 64'(imem_req_valid), 64'd0);
        cycle(0, 1, 0, 1, 1, 32'h2002);
        chk("rd_pc_next", 64'(pc_next), 64'h2000);
        chk("rd_req_valid", 64'(imem_req_valid), 64'd0);
        dlv.delete();
        cycle(0, 1, 1, 1, 0, 0);
        chk("rd_flushed", 64'(id_valid), 64'd0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 1, 0, 0);
        chk("rd_deliv_cnt", 64'(dlv.size() > 0), 64'd1);
        if (dlv.size() > 0) chk("rd_first_pc", 64'(dlv[0]), 64'h2000);

        // Redirect coincident with a response and a decode pop.
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 1, 1, 1, 32'h3000 + 32'(k * 64));
            cycle(0, 1, 1, 1, 0, 0);
            chk("co_no_stale", 64'(id_valid), 64'd0);
            for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, 0, 0);
        end

        // Memory stall.
        cycle(0, 0, 1, 1, 0, 0);
        a0 = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 1, 0, 0);
            chk("stall_addr", 64'(imem_req_addr), 64'(a0));
            chk("stall_pc_hold", 64'(pc_next), 64'(pc_current));
        end

        // Address wrap.
        cycle(0, 1, 1, 1, 1, 32'hFFFF_FFFE);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(0, 1, 1, 1, 0, 0);
            if (imem_req_valid && imem_req_addr == 32'hFFFF_FFFC) begin
                found = 1;
                chk("wrap_pc_next", 64'(pc_next), 64'h0);
            end
        end
        chk("wrap_found", 64'(found), 64'd1);

        // Randomized traffic with a mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500 || i == 1501)
                cycle(1, 1, 1, 1, 0, 0);
            else
                cycle(0, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0,
                      ($urandom % 16) == 0, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
